// File: rtl/disp_pkg.sv
// Shared display definitions.
//   - Segment codes for the active-low {g,f,e,d,c,b,a} 7-segment bus.
//   - Active-low one-hot anode patterns for the 8 digit positions.
//   - Source indices and the one-hot ownership encoding used by the arbiter.
package disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN0 = 8'hFE;
  localparam logic [7:0] AN1 = 8'hFD;
  localparam logic [7:0] AN2 = 8'hFB;
  localparam logic [7:0] AN3 = 8'hF7;
  localparam logic [7:0] AN4 = 8'hEF;
  localparam logic [7:0] AN5 = 8'hDF;
  localparam logic [7:0] AN6 = 8'hBF;
  localparam logic [7:0] AN7 = 8'h7F;

  localparam logic [1:0] SRC_TIME = 2'd0;
  localparam logic [1:0] SRC_LAP  = 2'd1;
  localparam logic [1:0] SRC_NOTE = 2'd2;

  // Ownership state is kept one-hot so it can drive the grant pins directly.
  typedef enum logic [2:0] {
    OWN_TIME = 3'b001,
    OWN_LAP  = 3'b010,
    OWN_NOTE = 3'b100
  } owner_e;

  function automatic owner_e idx_to_owner(input logic [1:0] idx);
    case (idx)
      SRC_LAP:  idx_to_owner = OWN_LAP;
      SRC_NOTE: idx_to_owner = OWN_NOTE;
      default:  idx_to_owner = OWN_TIME;
    endcase
  endfunction

  function automatic logic [7:0] an_onehot(input logic [2:0] d);
    case (d)
      3'd0:    an_onehot = AN0;
      3'd1:    an_onehot = AN1;
      3'd2:    an_onehot = AN2;
      3'd3:    an_onehot = AN3;
      3'd4:    an_onehot = AN4;
      3'd5:    an_onehot = AN5;
      3'd6:    an_onehot = AN6;
      default: an_onehot = AN7;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment decoder.
//   nibble_i : 4-bit value; 0-9 digits, A = dash, B-F = blank
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_DASH;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: shares the 8-digit 7-segment display between three sources
// (src0 live time, src1 lap/set view, src2 notifications).
//   clk, reset_n            : clock, asynchronous active-low reset
//   req[2:0]                : per-source request, req[0] ignored (src0 always requests)
//   digits0/1/2             : 8 nibbles per source, [3:0] is the rightmost digit
//   blank0/1/2              : per-digit blank mask, 1 = digit off
//   seg, an                 : registered active-low segments / anodes
//   grant                   : one-hot current owner (this is the arbiter state)
//   owner_changed           : one-cycle pulse on every ownership switch
//
// Handshake: there is no valid/ready pair; a source asserts req and must keep
// its digits/blank stable for as long as it requests. Ownership is granted by
// fixed priority (src2 > src1 > src0); a higher candidate preempts at once, a
// lower one only takes over after the owner's hold time has run out.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int SCAN_DIV    = 16,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [31:0] digits0,
  input  logic [31:0] digits1,
  input  logic [31:0] digits2,
  input  logic [7:0]  blank0,
  input  logic [7:0]  blank1,
  input  logic [7:0]  blank2,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic [2:0]  grant,
  output logic        owner_changed
);

  localparam int SW = SCAN_DIV + 3;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  owner_e          grant_q, grant_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic            changed_q, changed_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      an_q, an_d;

  logic [1:0]      owner_idx, cand_idx;
  logic            switch_en;
  logic [2:0]      digit_idx;
  logic [31:0]     digits_sel;
  logic [7:0]      blank_sel;
  logic [3:0]      nibble;

  // src0 always counts as requesting, so its request bit carries no information.
  logic unused_req0;
  assign unused_req0 = req[0];

  always_comb begin
    owner_idx = SRC_TIME;
    case (grant_q)
      OWN_LAP:  owner_idx = SRC_LAP;
      OWN_NOTE: owner_idx = SRC_NOTE;
      default:  owner_idx = SRC_TIME;
    endcase
  end

  assign cand_idx  = req[2] ? SRC_NOTE : (req[1] ? SRC_LAP : SRC_TIME);
  // Preemption ignores the hold counter; release waits for it to drain.
  assign switch_en = (cand_idx > owner_idx) ||
                     ((cand_idx < owner_idx) && (hold_q == '0));

  assign digit_idx = scan_q[SW-1:SCAN_DIV];

  always_comb begin
    digits_sel = digits0;
    blank_sel  = blank0;
    case (owner_idx)
      SRC_LAP: begin
        digits_sel = digits1;
        blank_sel  = blank1;
      end
      SRC_NOTE: begin
        digits_sel = digits2;
        blank_sel  = blank2;
      end
      default: begin
        digits_sel = digits0;
        blank_sel  = blank0;
      end
    endcase
  end

  assign nibble = digits_sel[{digit_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_d)
  );

  always_comb begin
    an_d = blank_sel[digit_idx] ? 8'hFF : an_onehot(digit_idx);
    if (switch_en) begin
      grant_d   = idx_to_owner(cand_idx);
      hold_d    = HOLD_RELOAD;
      scan_d    = '0;             // new owner starts at the rightmost digit
      changed_d = 1'b1;
    end else begin
      grant_d   = grant_q;
      hold_d    = (hold_q == '0) ? '0 : hold_q - HW'(1);
      scan_d    = scan_q + SW'(1);
      changed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= OWN_TIME;
      hold_q    <= '0;
      scan_q    <= '0;
      changed_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= 8'hFF;
    end else begin
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      scan_q    <= scan_d;
      changed_q <= changed_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign grant         = grant_q;
  assign owner_changed = changed_q;
  assign seg           = seg_q;
  assign an            = an_q;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

  localparam int SCAN_DIV = 2;
  localparam int HOLD     = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] digits0 = '0, digits1 = '0, digits2 = '0;
  logic [7:0]  blank0 = '0, blank1 = '0, blank2 = '0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [2:0]  grant;
  logic        owner_changed;

  always #5 clk = ~clk;

  display_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .digits0       (digits0),
    .digits1       (digits1),
    .digits2       (digits2),
    .blank0        (blank0),
    .blank1        (blank1),
    .blank2        (blank2),
    .seg           (seg),
    .an            (an),
    .grant         (grant),
    .owner_changed (owner_changed)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ownership is tracked as a source number plus the count of edges since the
  // last switch; that count is both the scan position and the hold age.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0111111;
    for (int i = 11; i < 16; i++) seg_tab[i] = 7'b1111111;
  end

  int         m_owner = 0;
  int         m_since = 0;
  bit         m_fresh = 1'b1;
  bit         m_pulse = 1'b0;
  logic [6:0] m_seg   = 7'h7F;
  logic [7:0] m_an    = 8'hFF;
  int         m_cand, m_d;
  logic [31:0] m_dg;
  logic [7:0]  m_bl;
  bit          m_sw;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = 0; m_since = 0; m_fresh = 1'b1; m_pulse = 1'b0;
      m_seg = 7'h7F; m_an = 8'hFF;
    end else begin
      m_cand = req[2] ? 2 : (req[1] ? 1 : 0);
      m_d    = (m_since >> SCAN_DIV) % 8;
      m_dg   = (m_owner == 2) ? digits2 : ((m_owner == 1) ? digits1 : digits0);
      m_bl   = (m_owner == 2) ? blank2  : ((m_owner == 1) ? blank1  : blank0);
      m_an   = m_bl[m_d] ? 8'hFF : ~(8'h01 << m_d);
      m_seg  = seg_tab[(m_dg >> (4 * m_d)) & 32'hF];
      // A lower source may take over once HOLD edges have elapsed since the switch.
      m_sw   = (m_cand > m_owner) ||
               ((m_cand < m_owner) && (m_fresh || m_since >= HOLD - 1));
      if (m_sw) begin
        m_owner = m_cand; m_since = 0; m_fresh = 1'b0; m_pulse = 1'b1;
      end else begin
        m_since++; m_pulse = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("grant", grant, 32'(1 << m_owner));
    check("owner_changed", owner_changed, m_pulse);
    check("an", an, m_an);
    check("seg", seg, m_seg);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] an_exp [8];
  logic [6:0] seg_exp [4];

  initial begin
    an_exp[0] = 8'hFE; an_exp[1] = 8'hFD; an_exp[2] = 8'hFB; an_exp[3] = 8'hF7;
    for (int i = 4; i < 8; i++) an_exp[i] = 8'hFF;
    seg_exp[0] = 7'b0011001; seg_exp[1] = 7'b0110000;
    seg_exp[2] = 7'b0100100; seg_exp[3] = 7'b1111001;

    digits0 = 32'h0000_1234; blank0 = 8'hF0;
    digits1 = 32'h0000_0000; blank1 = 8'h00;
    digits2 = 32'h8765_4321; blank2 = 8'h00;
    req = 3'b000;
    tick(2);
    check("rst_grant", grant, 3'b001);
    check("rst_pulse", owner_changed, 1'b0);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 8'hFF);

    // scan of src0 after reset release
    reset_n = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      tick(1);
      if ((j - 1) % 4 == 0) begin
        check("scan_an", an, an_exp[(j - 1) / 4]);
        if (j <= 16) check("scan_seg", seg, seg_exp[(j - 1) / 4]);
      end
    end
    check("scan_grant", grant, 3'b001);

    // one-cycle src2 pulse preempts, then holds for HOLD cycles
    req = 3'b100;
    tick(1);
    check("pre_grant", grant, 3'b100);
    check("pre_pulse", owner_changed, 1'b1);
    req = 3'b000;
    tick(1);
    check("pre_an_restart", an, 8'hFE);
    check("pre_pulse_low", owner_changed, 1'b0);
    tick(6);
    check("hold_grant", grant, 3'b100);
    tick(1);
    check("rel_grant", grant, 3'b001);
    check("rel_pulse", owner_changed, 1'b1);

    // src1 owns with hold 5 left, src2 preempts immediately
    digits1 = 32'h0000_0FBA;
    req = 3'b010;
    tick(1);
    check("lap_grant", grant, 3'b010);
    tick(2);
    req = 3'b110;
    tick(1);
    check("preempt_grant", grant, 3'b100);
    check("preempt_pulse", owner_changed, 1'b1);

    // src2 releases in the same cycle req[1] rises: direct 100 -> 010
    req = 3'b000;
    tick(7);
    check("sim_hold", grant, 3'b100);
    req = 3'b010;
    tick(1);
    check("sim_grant", grant, 3'b010);
    check("sim_pulse", owner_changed, 1'b1);

    // decode of A, B, F on src1
    tick(1);
    check("dash_seg", seg, 7'b0111111);
    check("dash_an", an, 8'hFE);
    check("sim_single_pulse", owner_changed, 1'b0);
    tick(4);
    check("b_seg", seg, 7'b1111111);
    check("b_an", an, 8'hFD);
    tick(4);
    check("f_seg", seg, 7'b1111111);
    check("f_an", an, 8'hFB);

    // asynchronous reset mid-scan while src1 owns
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_seg", seg, 7'h7F);
    check("arst_an", an, 8'hFF);
    check("arst_grant", grant, 3'b001);
    check("arst_pulse", owner_changed, 1'b0);
    req = 3'b000;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_an", an, 8'hFE);
    check("post_rst_seg", seg, 7'b0011001);
    check("post_rst_grant", grant, 3'b001);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick(1);
      if ($urandom_range(0, 99) < 8) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) begin
        digits0 = $urandom; digits1 = $urandom; digits2 = $urandom;
        blank0 = 8'($urandom); blank1 = 8'($urandom); blank2 = 8'($urandom);
      end
      if ($urandom_range(0, 999) < 3) begin
        #2 reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
      end
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
